// File: rtl/ex_muldiv_hilo_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_hilo_unit_if
//  Brief    : ID/EX-side command and HI/LO result bundle of the mul/div unit.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_hilo_unit
//  Brief    : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input wire                   clk,
  input wire                   reset,
  ex_muldiv_hilo_unit_if.slave bus
);
  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_pend;
  logic               r_is_div;
  logic               r_sign_rs;
  logic               r_sign_rt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;       // product high half / partial remainder
  logic [WIDTH-1:0]   r_b;       // product low half + multiplier / quotient + dividend
  logic [WIDTH-1:0]   r_m;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_rs_raw;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_busy;
  logic               w_done;
  logic               w_accept;
  logic               w_signed;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // The accepted command waits one cycle in IDLE (r_pend) before RUN starts.
  assign w_accept = bus.start && (((r_state == ST_IDLE) && !r_pend) || (r_state == ST_DONE));
  assign w_signed = ~bus.op[0];
  assign w_rs_mag = (w_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign w_rt_mag = (w_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  assign w_sum   = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_a, r_b[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};

  assign w_prod     = {r_a, r_b};
  assign w_prod_fix = (r_sign_rs ^ r_sign_rt) ? -w_prod : w_prod;

  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_m == '0) begin
        w_fix_hi = r_rs_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_sign_rs ? -r_a : r_a;
        w_fix_lo = (r_sign_rs ^ r_sign_rt) ? -r_b : r_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (r_pend) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_cnt_last) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend    <= 1'b0;
      r_is_div  <= 1'b0;
      r_sign_rs <= 1'b0;
      r_sign_rt <= 1'b0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_rs_raw  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_accept) begin
        r_pend    <= 1'b1;
        r_is_div  <= bus.op[1];
        r_sign_rs <= w_signed & bus.rs_val[WIDTH-1];
        r_sign_rt <= w_signed & bus.rt_val[WIDTH-1];
        r_rs_raw  <= bus.rs_val;
        r_a       <= '0;
        r_b       <= bus.op[1] ? w_rs_mag : w_rt_mag;
        r_m       <= bus.op[1] ? w_rt_mag : w_rs_mag;
      end else if ((r_state == ST_IDLE) && r_pend) begin
        r_pend <= 1'b0;
        r_cnt  <= '0;
      end

      if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + 1'b1;
        if (!r_is_div) begin
          r_a <= w_sum[WIDTH:1];
          r_b <= {w_sum[0], r_b[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
          r_a <= w_diff[WIDTH-1:0];
          r_b <= {r_b[WIDTH-2:0], 1'b1};
        end else begin
          r_a <= w_shift[WIDTH-1:0];
          r_b <= {r_b[WIDTH-2:0], 1'b0};
        end
      end

      if (r_state == ST_FIX) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (!w_busy) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv_hilo_unit
//  Brief    : Directed self-checking bench for the HI/LO mul/div unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv_hilo_unit;
  localparam logic [1:0] c_mult  = 2'b00;
  localparam logic [1:0] c_multu = 2'b01;
  localparam logic [1:0] c_div   = 2'b10;
  localparam logic [1:0] c_divu  = 2'b11;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  ex_muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one start pulse; returns at the negedge just after the sampling edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      busy_n += int'(bus.busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int busy_n;
    launch(op, a, b);
    wait_done(lat, busy_n);
    check({tag, "_latency"}, 32'(lat), 32'd34);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int lat;
    int busy_n;
    int pulses;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;

    run_op("multu_max", c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("hold_lo", bus.lo, 32'h0000_0001);

    run_op("mult_neg", c_mult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_minsq", c_mult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg", c_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdiv", c_div, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    run_op("divu_zero", c_divu, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_zero", c_div, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu_big", c_divu, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("div_ovf", c_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI alone, then MTHI+MTLO in the same cycle
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_hi", bus.hi, 32'h0000_1234);
    check("mthi_lo_kept", bus.lo, 32'h8000_0000);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthilo_hi", bus.hi, 32'hA5A5_5A5A);
    check("mthilo_lo", bus.lo, 32'hA5A5_5A5A);

    // Reset while RUN is at cnt=10 aborts with no later done pulse
    launch(c_multu, 32'd5, 32'd5);
    repeat (11) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(bus.done);
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    // Ignored start in RUN, ignored MTHI in FIX, back-to-back start in DONE
    launch(c_multu, 32'd5, 32'd5);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      bus.start  = (lat == 5);
      bus.hi_we  = (lat == 33);
      bus.wdata  = 32'hDEAD_BEEF;
      bus.rs_val = 32'd3;
      bus.rt_val = 32'd3;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("b2b_first_latency", 32'(lat), 32'd34);
    check("b2b_first_lo", bus.lo, 32'd25);
    check("b2b_first_hi", bus.hi, 32'd0);
    bus.start  = 1'b1;
    bus.op     = c_multu;
    bus.rs_val = 32'd6;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    check("b2b_second_latency", 32'(lat), 32'd34);
    check("b2b_second_busy", 32'(busy_n), 32'd33);
    check("b2b_second_lo", bus.lo, 32'd42);
    check("b2b_second_hi", bus.hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
